// File: rtl/bsg_fsb_node_ls_rx_fifo.sv
// Receive FIFO on the fsb side of the node->fsb level shifters, gated by an isolation/wake FSM.
// Optional: define BSG_FSB_NODE_LS_RX_FIFO_FLUSH_ON_ISO_EN to clear the FIFO whenever the node re-isolates.
module bsg_fsb_node_ls_rx_fifo #(
    parameter int width_p       = 5,
    parameter int els_p         = 4,
    parameter int wake_cycles_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_ls_i,
    input  logic                       node_v_i,
    input  logic [width_p-1:0]         node_data_i,
    output logic                       node_ready_o,
    output logic                       fsb_v_o,
    output logic [width_p-1:0]         fsb_data_o,
    input  logic                       fsb_yumi_i,
    output logic                       iso_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w_lp  = $clog2(els_p);
    localparam int cnt_w_lp  = $clog2(els_p + 1);
    localparam int wake_w_lp = (wake_cycles_p > 1) ? $clog2(wake_cycles_p) : 1;

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [wake_w_lp-1:0]   wake_cnt_q, wake_cnt_d;
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]    count_q, count_d;
    logic [width_p-1:0]     mem_q [els_p];

    logic full, empty, enq, deq, flush;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ST_ISO;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_ISO: begin
                if (en_ls_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = wake_w_lp'(wake_cycles_p - 1);
                end
            end
            ST_WAKE: begin
                if (!en_ls_i)
                    state_d = ST_ISO;
                else if (wake_cnt_q == '0)
                    state_d = ST_ACTIVE;
                else
                    wake_cnt_d = wake_cnt_q - wake_w_lp'(1);
            end
            ST_ACTIVE: begin
                if (!en_ls_i)
                    state_d = ST_ISO;
            end
            default: state_d = ST_ISO;
        endcase
    end

    // Ready tracks en_ls_i combinationally so a falling enable blocks the same-cycle word.
    always_comb begin
        iso_o        = (state_q != ST_ACTIVE);
        node_ready_o = (state_q == ST_ACTIVE) && en_ls_i && !full;
    end

`ifdef BSG_FSB_NODE_LS_RX_FIFO_FLUSH_ON_ISO_EN
    assign flush = (state_q != ST_ISO) && (state_d == ST_ISO);
`else
    assign flush = 1'b0;
`endif

    assign full    = (count_q == cnt_w_lp'(els_p));
    assign empty   = (count_q == '0);
    assign enq     = node_v_i && node_ready_o;
    assign deq     = fsb_yumi_i && !empty;

    assign fsb_v_o    = !empty;
    assign fsb_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Pointers rely on els_p being a power of two to wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
            if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
            if (enq && !deq)
                count_d = count_q + cnt_w_lp'(1);
            else if (!enq && deq)
                count_d = count_q - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem_q[wr_ptr_q] <= node_data_i;
    end

    yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_i)
                                      !(fsb_yumi_i && empty));

endmodule

// File: tb/tb_bsg_fsb_node_ls_rx_fifo.sv
// Directed self-checking bench for bsg_fsb_node_ls_rx_fifo (width 5, depth 4, wake 8).
module tb_bsg_fsb_node_ls_rx_fifo;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       en_ls_i;
    logic       node_v_i;
    logic [4:0] node_data_i;
    logic       node_ready_o;
    logic       fsb_v_o;
    logic [4:0] fsb_data_o;
    logic       fsb_yumi_i;
    logic       iso_o;
    logic [2:0] count_o;

    int checks;
    int errors;
    logic [4:0] exp_data [8];

    bsg_fsb_node_ls_rx_fifo #(.width_p(5), .els_p(4), .wake_cycles_p(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_ls_i     (en_ls_i),
        .node_v_i    (node_v_i),
        .node_data_i (node_data_i),
        .node_ready_o(node_ready_o),
        .fsb_v_o     (fsb_v_o),
        .fsb_data_o  (fsb_data_o),
        .fsb_yumi_i  (fsb_yumi_i),
        .iso_o       (iso_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance past one rising edge; inputs change and checks occur 2 time units later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        tick();
        tick();
        reset_i = 1'b1;
        #1;
        checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", node_ready_o); end
        checks++; if (fsb_v_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fsb_v: got %b expected 0", fsb_v_o); end
        checks++; if (fsb_data_o !== 5'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", fsb_data_o); end
        checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_iso: got %b expected 1", iso_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_wake();
        en_ls_i = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL wake_iso[%0d]: got %b expected 1", i, iso_o); end
            checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL wake_ready[%0d]: got %b expected 0", i, node_ready_o); end
            tick();
        end
        checks++; if (iso_o !== 1'b0) begin errors++; $display("[TB] FAIL wake_active_iso: got %b expected 0", iso_o); end
        checks++; if (node_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL wake_active_ready: got %b expected 1", node_ready_o); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            node_v_i    = 1'b1;
            node_data_i = 5'(i);
            #1;
            checks++; if (node_ready_o !== (i <= 4)) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", i, node_ready_o, (i <= 4)); end
            tick();
        end
        node_v_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count_o); end
        checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_ready: got %b expected 0", node_ready_o); end
        fsb_yumi_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (fsb_v_o !== 1'b1) begin errors++; $display("[TB] FAIL drain_v[%0d]: got %b expected 1", k, fsb_v_o); end
            checks++; if (fsb_data_o !== 5'(k)) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", k, fsb_data_o, 5'(k)); end
            tick();
        end
        fsb_yumi_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 0", count_o); end
        checks++; if (fsb_v_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_v: got %b expected 0", fsb_v_o); end
        checks++; if (fsb_data_o !== 5'h00) begin errors++; $display("[TB] FAIL drain_empty_data: got %h expected 00", fsb_data_o); end
    endtask

    task automatic test_back_to_back();
        exp_data = '{5'h0A, 5'h0B, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15};
        node_v_i    = 1'b1;
        node_data_i = 5'h0A;
        tick();
        node_data_i = 5'h0B;
        tick();
        fsb_yumi_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            node_data_i = 5'h10 + 5'(i);
            #1;
            checks++; if (count_o !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, count_o); end
            checks++; if (fsb_data_o !== exp_data[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, fsb_data_o, exp_data[i]); end
            tick();
        end
        node_v_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fsb_data_o !== exp_data[6+i]) begin errors++; $display("[TB] FAIL b2b_tail[%0d]: got %h expected %h", i, fsb_data_o, exp_data[6+i]); end
            tick();
        end
        fsb_yumi_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL b2b_final_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_iso_drop();
        exp_data[0] = 5'h1C;
        exp_data[1] = 5'h1D;
        exp_data[2] = 5'h1E;
        node_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            node_data_i = exp_data[i];
            tick();
        end
        node_v_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd3) begin errors++; $display("[TB] FAIL iso_pre_count: got %0d expected 3", count_o); end
        en_ls_i = 1'b0;
        #1;
        checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL iso_ready_same_cycle: got %b expected 0", node_ready_o); end
        checks++; if (iso_o !== 1'b0) begin errors++; $display("[TB] FAIL iso_still_active: got %b expected 0", iso_o); end
        tick();
        checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL iso_entered: got %b expected 1", iso_o); end
`ifdef BSG_FSB_NODE_LS_RX_FIFO_FLUSH_ON_ISO_EN
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL iso_flush_count: got %0d expected 0", count_o); end
        checks++; if (fsb_v_o !== 1'b0) begin errors++; $display("[TB] FAIL iso_flush_v: got %b expected 0", fsb_v_o); end
`else
        checks++; if (count_o !== 3'd3) begin errors++; $display("[TB] FAIL iso_keep_count: got %0d expected 3", count_o); end
        checks++; if (fsb_v_o !== 1'b1) begin errors++; $display("[TB] FAIL iso_keep_v: got %b expected 1", fsb_v_o); end
`endif
        en_ls_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef BSG_FSB_NODE_LS_RX_FIFO_FLUSH_ON_ISO_EN
            fsb_yumi_i = 1'b0;
`else
            fsb_yumi_i = (i < 3);
`endif
            #1;
            checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL rewake_iso[%0d]: got %b expected 1", i, iso_o); end
            checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rewake_ready[%0d]: got %b expected 0", i, node_ready_o); end
            if (fsb_yumi_i) begin
                checks++; if (fsb_data_o !== exp_data[i]) begin errors++; $display("[TB] FAIL iso_drain_data[%0d]: got %h expected %h", i, fsb_data_o, exp_data[i]); end
            end
            tick();
        end
        fsb_yumi_i = 1'b0;
        #1;
        checks++; if (iso_o !== 1'b0) begin errors++; $display("[TB] FAIL rewake_active_iso: got %b expected 0", iso_o); end
        checks++; if (node_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rewake_active_ready: got %b expected 1", node_ready_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL rewake_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_wake_abort();
        en_ls_i = 1'b0;
        tick();
        en_ls_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_iso[%0d]: got %b expected 1", i, iso_o); end
            tick();
        end
        en_ls_i = 1'b0;
        tick();
        checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_iso: got %b expected 1", iso_o); end
        en_ls_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_rewake_iso[%0d]: got %b expected 1", i, iso_o); end
            checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_rewake_ready[%0d]: got %b expected 0", i, node_ready_o); end
            tick();
        end
        #1;
        checks++; if (iso_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_active_iso: got %b expected 0", iso_o); end
        checks++; if (node_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_active_ready: got %b expected 1", node_ready_o); end
    endtask

    task automatic test_reset_full();
        node_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            node_data_i = 5'h15 + 5'(i);
            tick();
        end
        node_v_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd4) begin errors++; $display("[TB] FAIL rf_pre_count: got %0d expected 4", count_o); end
        checks++; if (fsb_data_o !== 5'h15) begin errors++; $display("[TB] FAIL rf_pre_data: got %h expected 15", fsb_data_o); end
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        #1;
        checks++; if (fsb_v_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_fsb_v: got %b expected 0", fsb_v_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL rf_count: got %0d expected 0", count_o); end
        checks++; if (iso_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_iso: got %b expected 1", iso_o); end
        checks++; if (node_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_ready: got %b expected 0", node_ready_o); end
        checks++; if (fsb_data_o !== 5'h00) begin errors++; $display("[TB] FAIL rf_data: got %h expected 00", fsb_data_o); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_i     = 1'b0;
        en_ls_i     = 1'b0;
        node_v_i    = 1'b0;
        node_data_i = 5'h00;
        fsb_yumi_i  = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_wake();
        test_fill();
        test_back_to_back();
        test_iso_drop();
        test_wake_abort();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_fsb_node_ls_rx_fifo.md
Name: bsg_fsb_node_ls_rx_fifo

Overview:
- Receive buffer on the fsb side of the fsb/node level-shift boundary. Directly downstream of the node-to-fsb level shifters.
- Consumes the shifted node valid/data stream and returns a ready. Buffers up to els_p words and presents them to the fsb with a valid/yumi interface.
- Tracks the shifter enable with an isolation/wake state machine, so no word is accepted while the node domain is isolated or still settling after power-up.

Parameters:
- width_p, 5: data width of node and fsb payload.
- els_p, 4: FIFO depth. Power of two, >= 2.
- wake_cycles_p, 8: cycles en_ls_i must stay high before accepting data. Must be >= 1.

Ports:
- clk_i  in  1  fsb-domain clock.
- reset_i  in  1  synchronous, active-low reset.
- en_ls_i  in  1  level-shifter enable; 1 = node domain powered and unisolated.
- node_v_i  in  1  shifted node valid.
- node_data_i  in  width_p  shifted node data.
- node_ready_o  out  1  ready back to node, through the shifter.
- fsb_v_o  out  1  buffered word valid to fsb.
- fsb_data_o  out  width_p  buffered word.
- fsb_yumi_i  in  1  fsb consumes fsb_data_o this cycle.
- iso_o  out  1  1 when state != ACTIVE.
- count_o  out  $clog2(els_p+1)  current occupancy.

Behaviour:
- Reset (reset_i == 0 at a clk_i edge):
  - state = ISO, wake counter = 0, FIFO empty, rd/wr pointers = 0.
  - Outputs after reset: node_ready_o=0, fsb_v_o=0, fsb_data_o=0, iso_o=1, count_o=0.
- States ISO, WAKE, ACTIVE; all transitions registered:
  - ISO: en_ls_i==1 -> WAKE, counter loads wake_cycles_p-1. Otherwise stay.
  - WAKE: en_ls_i==0 -> ISO. If counter==0 -> ACTIVE. Otherwise decrement.
  - ACTIVE: en_ls_i==0 -> ISO. Otherwise stay.
  - With wake_cycles_p=1, ACTIVE is entered 2 edges after en_ls_i rises.
- node_ready_o = (state==ACTIVE) & en_ls_i & ~full. Combinational from registered state/full and the en_ls_i input.
- Enqueue = node_v_i & node_ready_o. Data written at wr_ptr; wr_ptr and count increment.
- node_v_i while node_ready_o==0 is ignored; no data loss accounting.
- fsb_v_o = ~empty, independent of state. The fsb side keeps draining while the node is isolated.
- fsb_data_o = mem[rd_ptr]; 0 when empty.
- Dequeue = fsb_yumi_i & fsb_v_o; rd_ptr increments.
- fsb_yumi_i while empty is a protocol error: simulation assertion; state unchanged.
- No bypass: a word enqueued at edge N is visible on fsb_v_o after edge N. Minimum latency 1 cycle.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance. Allowed at any nonzero occupancy below full.
- When full, ready is 0, so enqueue+dequeue cannot happen together at full.
- Pointers wrap modulo els_p. full = (count==els_p), empty = (count==0).
- en_ls_i falling mid-transfer: ready drops in the same cycle (combinational). A word is accepted only if en_ls_i==1 at the edge.
- Reset mid-operation discards all contents and returns to ISO.

Optional Feature:
- Macro: BSG_FSB_NODE_LS_RX_FIFO_FLUSH_ON_ISO_EN.
- Defined: on the edge where state goes ACTIVE->ISO or WAKE->ISO, the FIFO is cleared (pointers and count to 0). Any same-cycle dequeue is overridden by the flush. The next cycle shows fsb_v_o=0, count_o=0.
- Undefined: contents are retained across isolation and drain normally.

Test Plan:
- Reset, then en_ls_i=1 held with wake_cycles_p=8:
  - node_ready_o=0 and iso_o=1 for 9 cycles after en_ls_i rises.
  - Then node_ready_o=1 and iso_o=0.
- ACTIVE, node_v_i=1 with data 5'h01..5'h05, fsb_yumi_i=0:
  - First 4 words accepted; count_o=4; node_ready_o=0.
  - 5th word is held off.
  - Then fsb_yumi_i=1 for 4 cycles yields 01,02,03,04 in order; count_o returns to 0.
- Occupancy 2, node_v_i=1 and fsb_yumi_i=1 for 6 cycles: count_o stays 2; output order matches input order across pointer wrap.
- ACTIVE with 3 words queued, en_ls_i pulled low for 1 cycle:
  - node_ready_o=0 the same cycle; iso_o=1 next cycle.
  - Full wake period required again.
  - Without macro: the 3 words still drain. With macro: fsb_v_o=0, count_o=0 next cycle.
- en_ls_i toggles high 4 cycles, low 1, high again: WAKE aborts to ISO and the counter restarts. ACTIVE is reached only after 8 consecutive high cycles.
- reset_i=0 for one edge while full: next cycle fsb_v_o=0, count_o=0, iso_o=1, node_ready_o=0.
